// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Falling edges per frame: load, start, 8 data, parity, stop.
    localparam logic [3:0] FRAME_EDGES = 4'd12;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit for a byte; 'odd' inverts the even-parity result.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Client request/grant bus plus the transmitter-facing strobes.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        tx_data;
    logic              wr_enable;
    logic              tx_enable;
    logic              parity;
    logic              tx_busy;
    logic              ctrl_busy;
    logic              err;

    modport master (
        output req, req_data, tx_busy,
        input  gnt, done, tx_data, wr_enable, tx_enable, parity, ctrl_busy, err
    );

    modport slave (
        input  req, req_data, tx_busy,
        output gnt, done, tx_data, wr_enable, tx_enable, parity, ctrl_busy, err
    );
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module uart_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                         req_i,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
    output logic [NREQ-1:0]                         gnt_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] idx_o,
    output logic                                    valid_o
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int            pos_s;
    logic [OW-1:0] cand_s;

    // Scan from the pointer; the first hit wins and later hits are ignored.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos_s   = 0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = int'(ptr_i) + k;
            if (pos_s >= NREQ) begin
                pos_s = pos_s - NREQ;
            end else begin
                pos_s = pos_s;
            end
            cand_s = OW'(pos_s);
            if (!valid_o && req_i[cand_s]) begin
                valid_o       = 1'b1;
                idx_o         = cand_s;
                gnt_o[cand_s] = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ requesters: arbitration, byte/parity
// latch, bit-step strobe generation and per-requester completion.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CLK_DIV    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_sched_if.slave  bus
);
    localparam int             OW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int             DW          = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF    = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0]  DIV_HALF_M1 = DW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0]  DIV_ONE     = DW'(1);
    localparam logic [OW-1:0]  OWN_LAST    = OW'(NREQ - 1);
    localparam logic [OW-1:0]  OWN_ONE     = OW'(1);
    localparam logic [3:0]     EDGE_ONE    = 4'd1;
    localparam logic           PAR_SEL     = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    state_t            state_q, state_d;
    logic              busy_meta_q, busy_s_q;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [DW-1:0]     div_q, div_d;
    logic [3:0]        edge_q, edge_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              parity_q, parity_d;
    logic              wr_en_q, wr_en_d;
    logic              tx_en_q, tx_en_d;
    logic              ctrl_busy_q, ctrl_busy_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [OW-1:0]     arb_idx_s;
    logic              arb_valid_s;
    logic [7:0]        sel_byte_s;

    uart_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    assign sel_byte_s = bus.req_data[{arb_idx_s, 3'b000} +: 8];

    // Two-flop synchronizer for the transmitter's asynchronous idle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= bus.tx_busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // Next-state and registered-output logic for IDLE -> SEND -> DONE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        div_d       = div_q;
        edge_d      = edge_q;
        gnt_d       = '0;
        done_d      = '0;
        tx_data_d   = tx_data_q;
        parity_d    = parity_q;
        wr_en_d     = wr_en_q;
        tx_en_d     = 1'b0;
        ctrl_busy_d = ctrl_busy_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s && busy_s_q) begin
                    tx_data_d   = sel_byte_s;
                    parity_d    = calc_parity(sel_byte_s, PAR_SEL);
                    gnt_d       = arb_gnt_s;
                    wr_en_d     = 1'b1;
                    ctrl_busy_d = 1'b1;
                    owner_d     = arb_idx_s;
                    div_d       = '0;
                    edge_d      = 4'd0;
                    tx_en_d     = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
                // Falling edge of tx_enable happens on this transition.
                if (div_q == DIV_HALF_M1) begin
                    edge_d = edge_q + EDGE_ONE;
                    if (edge_q == 4'd0) begin
                        wr_en_d = 1'b0;
                    end else begin
                        wr_en_d = wr_en_q;
                    end
                end else begin
                    edge_d = edge_q;
                end
                if ((div_q == DIV_LAST) && (edge_q == FRAME_EDGES)) begin
                    state_d = ST_DONE;
                    tx_en_d = 1'b0;
                end else begin
                    tx_en_d = (div_d < DIV_HALF);
                end
            end
            ST_DONE: begin
                done_d[owner_q] = 1'b1;
                if (!busy_s_q) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                ptr_d       = (owner_q == OWN_LAST) ? '0 : (owner_q + OWN_ONE);
                ctrl_busy_d = 1'b0;
                wr_en_d     = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            div_q       <= '0;
            edge_q      <= 4'd0;
            gnt_q       <= '0;
            done_q      <= '0;
            tx_data_q   <= 8'h00;
            parity_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            ctrl_busy_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            div_q       <= div_d;
            edge_q      <= edge_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            tx_data_q   <= tx_data_d;
            parity_q    <= parity_d;
            wr_en_q     <= wr_en_d;
            tx_en_q     <= tx_en_d;
            ctrl_busy_q <= ctrl_busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.parity    = parity_q;
    assign bus.wr_enable = wr_en_q;
    assign bus.tx_enable = tx_en_q;
    assign bus.ctrl_busy = ctrl_busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: even- and odd-parity schedulers driven in lockstep,
// grants scored against a queue of expected captures.
module tb_uart_tx_sched;
    localparam int NREQ    = 4;
    localparam int CLK_DIV = 16;

    typedef struct {
        logic [3:0] req;
        int         lane;
        logic [7:0] data;
        logic [3:0] exp_gnt;
        logic       exp_p0;
        logic       exp_p1;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic       p0;
        logic       p1;
    } exp_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  req_r      = 4'b0000;
    logic [31:0] req_data_r = 32'h0000_0000;
    logic        tx_busy_r  = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    int         cyc = 0;
    int         gnt_cyc = 0;
    int         last_done_cyc = 0;
    int         falls = 0;
    bit         frame_active = 1'b0;
    bit         done_seen = 1'b0;
    bit         b2b_en = 1'b0;
    bit         prev_en = 1'b0;
    logic [3:0] cur_gnt = 4'b0000;
    logic [7:0] cur_data = 8'h00;

    uart_tx_sched_if #(.NREQ(NREQ)) bus0 ();
    uart_tx_sched_if #(.NREQ(NREQ)) bus1 ();

    assign bus0.req      = req_r;
    assign bus0.req_data = req_data_r;
    assign bus0.tx_busy  = tx_busy_r;
    assign bus1.req      = req_r;
    assign bus1.req_data = req_data_r;
    assign bus1.tx_busy  = tx_busy_r;

    uart_tx_sched #(.NREQ(NREQ), .CLK_DIV(CLK_DIV), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    uart_tx_sched #(.NREQ(NREQ), .CLK_DIV(CLK_DIV), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_gnt(input int limit, input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (bus0.gnt != 4'b0000) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    task automatic wait_done(input int limit, input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (bus0.done != 4'b0000) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic p0, input logic p1);
        exp_t e;
        e.gnt = g; e.data = d; e.p0 = p0; e.p1 = p1;
        exp_q.push_back(e);
    endtask

    // Monitor: scores grants, strobe timing and completions away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                frame_active = 1'b0;
                prev_en      = 1'b0;
            end else begin
                if (bus0.gnt != 4'b0000) begin
                    chk("sb_has_entry", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = '{default: '0};
                    chk("gnt0", bus0.gnt, e.gnt);
                    chk("gnt1", bus1.gnt, e.gnt);
                    chk("tx_data0", bus0.tx_data, e.data);
                    chk("tx_data1", bus1.tx_data, e.data);
                    chk("parity_even", bus0.parity, e.p0);
                    chk("parity_odd", bus1.parity, e.p1);
                    chk("wr_enable_at_gnt", bus0.wr_enable, 1);
                    chk("ctrl_busy_at_gnt", bus0.ctrl_busy, 1);
                    if (b2b_en && done_seen) chk("idle_gap", cyc - last_done_cyc, 1);
                    gnt_cyc      = cyc;
                    frame_active = 1'b1;
                    falls        = 0;
                    cur_gnt      = e.gnt;
                    cur_data     = e.data;
                end
                if (prev_en && !bus0.tx_enable) begin
                    falls++;
                    if (falls == 1) begin
                        chk("first_fall_latency", cyc - gnt_cyc, CLK_DIV / 2);
                        chk("wr_enable_cleared", bus0.wr_enable, 0);
                    end
                end
                if (bus0.done != 4'b0000) begin
                    chk("done_in_frame", frame_active, 1);
                    chk("done_owner", bus0.done, cur_gnt);
                    chk("done_latency", cyc - gnt_cyc, 12 * CLK_DIV + 1);
                    chk("fall_count", falls, 12);
                    chk("tx_data_held", bus0.tx_data, cur_data);
                    chk("ctrl_busy_at_done", bus0.ctrl_busy, 0);
                    frame_active  = 1'b0;
                    last_done_cyc = cyc;
                    done_seen     = 1'b1;
                end
                prev_en = bus0.tx_enable;
            end
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{4'b0100, 2, 8'hA5, 4'b0100, 1'b0, 1'b1};
        vecs[1] = '{4'b0001, 0, 8'h01, 4'b0001, 1'b1, 1'b0};
        vecs[2] = '{4'b0001, 0, 8'h00, 4'b0001, 1'b0, 1'b1};
        vecs[3] = '{4'b0010, 1, 8'h80, 4'b0010, 1'b1, 1'b0};
        vecs[4] = '{4'b0110, 2, 8'h3C, 4'b0100, 1'b0, 1'b1};
        vecs[5] = '{4'b1000, 3, 8'hFF, 4'b1000, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus0.gnt, bus0.done, bus0.tx_data, bus0.wr_enable,
                              bus0.tx_enable, bus0.parity, bus0.ctrl_busy, bus0.err}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven single transfers (parity, lane selection, rotation)
        for (int i = 0; i < 6; i++) begin
            req_data_r = 32'hEEEE_EEEE;
            req_data_r[vecs[i].lane*8 +: 8] = vecs[i].data;
            push_exp(vecs[i].exp_gnt, vecs[i].data, vecs[i].exp_p0, vecs[i].exp_p1);
            req_r = vecs[i].req;
            wait_gnt(10, "tbl_gnt");
            req_r = 4'b0000;
            wait_done(300, "tbl_done");
            repeat (2) @(negedge clk);
        end

        // All requesters held: strict rotation, back-to-back frames
        push_exp(4'b0001, 8'h11, 1'b0, 1'b1);
        push_exp(4'b0010, 8'h22, 1'b0, 1'b1);
        push_exp(4'b0100, 8'h33, 1'b0, 1'b1);
        push_exp(4'b1000, 8'h44, 1'b0, 1'b1);
        push_exp(4'b0001, 8'h11, 1'b0, 1'b1);
        req_data_r = 32'h4433_2211;
        req_r = 4'b1111;
        wait_gnt(10, "rr_gnt_first");
        @(negedge clk);
        b2b_en = 1'b1;
        for (int k = 1; k < 5; k++) wait_gnt(250, "rr_gnt_next");
        req_r = 4'b0000;
        wait_done(300, "rr_done");
        b2b_en = 1'b0;
        repeat (2) @(negedge clk);

        // Transmitter not ready: request waits, then is granted after sync
        tx_busy_r = 1'b0;
        repeat (3) @(negedge clk);
        req_data_r = 32'hEEEE_EE5A;
        req_r = 4'b0001;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.gnt != 4'b0000) seen = 1'b1;
        end
        chk("busy_low_no_gnt", seen, 0);
        push_exp(4'b0001, 8'h5A, 1'b0, 1'b1);
        tx_busy_r = 1'b1;
        wait_gnt(3, "busy_release_gnt");
        req_r = 4'b0000;
        wait_done(300, "busy_release_done");
        chk("err_clear", bus0.err, 0);
        repeat (2) @(negedge clk);

        // Transmitter stuck busy at frame end: sticky error
        req_data_r = 32'hEEEE_07EE;
        push_exp(4'b0010, 8'h07, 1'b1, 1'b0);
        req_r = 4'b0010;
        wait_gnt(10, "err_gnt");
        req_r = 4'b0000;
        repeat (50) @(negedge clk);
        tx_busy_r = 1'b0;
        wait_done(300, "err_done");
        chk("err_set_even", bus0.err, 1);
        chk("err_set_odd", bus1.err, 1);
        tx_busy_r = 1'b1;
        repeat (10) @(negedge clk);
        chk("err_sticky", bus0.err, 1);

        // Reset mid-frame: immediate clear, no done, pointer back to 0
        req_data_r = 32'hF0EE_EEEE;
        push_exp(4'b1000, 8'hF0, 1'b0, 1'b1);
        req_r = 4'b1000;
        wait_gnt(10, "rst_gnt");
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (falls >= 5) seen = 1'b1;
        end
        chk("rst_reached_fifth_fall", seen, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", {bus0.gnt, bus0.done, bus0.tx_data, bus0.wr_enable,
                                  bus0.tx_enable, bus0.parity, bus0.ctrl_busy, bus0.err}, 0);
        chk("rst_async_err_odd", bus1.err, 0);
        req_data_r = 32'hF0EE_EE81;
        req_r = 4'b1001;
        repeat (3) @(negedge clk);
        push_exp(4'b0001, 8'h81, 1'b0, 1'b1);
        reset = 1'b0;
        wait_gnt(10, "post_rst_gnt");
        req_r = 4'b0000;
        wait_done(300, "post_rst_done");
        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Controller/scheduler that shares one UART transmitter (`tx_fsm`) among NREQ requesters.
- Runs on the system clock. Round-robin arbitrates requests and latches the winner's byte, computing its parity.
- Generates the transmitter's bit-step strobe (`tx_enable`) and load strobe (`wr_enable`), and reports per-requester grant/completion.
- Sits between client logic and `tx_fsm`; `tx_fsm` steps only on falling edges of `tx_enable`.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CLK_DIV, 16, clk cycles per serial bit; even, >= 4.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester transmit request, level
- req_data  input  8*NREQ  byte i at [8i+7:8i]
- gnt  output  NREQ  one-cycle pulse: byte i captured
- done  output  NREQ  one-cycle pulse: frame for requester i finished
- tx_data  output  8  byte to transmitter
- wr_enable  output  1  load request to transmitter
- tx_enable  output  1  bit strobe; transmitter acts on its falling edge
- parity  output  1  parity bit to transmitter
- tx_busy  input  1  transmitter status: 1 = idle/ready, 0 = frame in progress; asynchronous to clk
- ctrl_busy  output  1  high from grant through DONE
- err  output  1  sticky: transmitter not idle at frame end

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; rr pointer = 0, so requester 0 has highest priority.
- Reset behaviour mid-frame:
  - Forcing `tx_enable` low may present a falling edge to the transmitter; it samples the same reset there.
  - The in-flight frame is abandoned; no `done`.
- `tx_busy` passes through a 2-flop synchronizer (`busy_s`); it is only ever sampled synchronized.
- State machine: IDLE -> SEND -> DONE -> IDLE.
- IDLE:
  - `tx_enable` = 0.
  - If |req and `busy_s` = 1: pick the first set req at or after the pointer, wrapping.
  - Same cycle register: `tx_data` = byte, `parity` = ^byte XOR PARITY_ODD, `gnt[i]` = 1 for exactly one cycle, `wr_enable` = 1, `ctrl_busy` = 1, owner = i, `div_cnt` = 0, `edge_cnt` = 0.
  - Go to SEND.
- SEND, strobe generation:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `tx_enable` = 1 while `div_cnt` < CLK_DIV/2, else 0.
  - A falling edge occurs when `div_cnt` goes CLK_DIV/2-1 -> CLK_DIV/2; `edge_cnt` increments there.
- SEND, frame length: one frame = 12 falling edges (load, start, 8 data, parity, stop).
  - `wr_enable` clears on the clk edge where `edge_cnt` becomes 1.
  - When `div_cnt` = CLK_DIV-1 and `edge_cnt` = 12, go to DONE.
  - SEND lasts exactly 12*CLK_DIV cycles.
- `tx_data` and `parity` are held constant throughout SEND.
- Changes on `req`/`req_data` after `gnt` are ignored.
- DONE (one cycle):
  - `done[owner]` = 1.
  - If `busy_s` = 0, set `err`; it stays set until reset.
  - Pointer = owner+1 mod NREQ.
  - `ctrl_busy` = 0; go to IDLE.
- Next grant is possible the following cycle, giving 1 idle cycle between frames.
- Latency: `gnt` to first falling edge = CLK_DIV/2 cycles; `gnt` to `done` = 12*CLK_DIV+1 cycles.
- Boundary conditions:
  - req with `busy_s` = 0: wait, no grant.
  - `req[i]` that drops before grant: not served.
  - Single requester held high: served back-to-back.
  - Simultaneous reqs: strict rotation.
- Widths: `div_cnt` = $clog2(CLK_DIV) bits; `edge_cnt` = 4 bits; owner = $clog2(NREQ) bits, minimum 1.

Decomposition:
- Package `uart_pkg`: state encoding (IDLE, SEND, DONE), FRAME_EDGES = 12, PARITY_EVEN/PARITY_ODD constants.
- One sub-module `uart_rr_arb`: combinational round-robin pick over req given pointer; outputs one-hot grant and index.
- Strobe counter and FSM stay in the top level.

Test Plan (NREQ=4, CLK_DIV=16):
1. req=4'b0100, byte2=8'hA5, tx_busy=1 -> `gnt`=4'b0100 one cycle; `tx_data`=A5, `parity`=0; first `tx_enable` fall 8 cycles after `gnt`; exactly 12 falls; `done`=4'b0100 at `gnt`+193.
2. req=4'b1111 held, bytes 11/22/33/44 -> grants in order 0,1,2,3,0; each `tx_data` matches; 1 idle cycle between `done` and next `gnt`.
3. PARITY_ODD=1, byte 8'h01 -> `parity`=0; PARITY_ODD=0, same byte -> `parity`=1; 8'h00 with even -> 0.
4. tx_busy=0, req=4'b0001 -> no `gnt` for 100 cycles; raise tx_busy -> `gnt` within 3 cycles.
5. Launch with tx_busy=1, drop it to 0 mid-frame and hold -> `err`=1 at DONE, `done` still pulses, `err` stays 1 until reset.
6. Assert reset after the 5th fall with `req[3]` served -> all outputs 0 immediately, no `done`; release with req=4'b1001 -> requester 0 granted first.
